// File: rtl/game_ctrl.sv
// game_ctrl: game-logic engine for the two-player finger-sum game.
// It turns key rising edges into page navigation, configuration changes and game moves.
// It also holds the complete game state for the page renderers.
module game_ctrl #(
  parameter int NUM_MIN  = 2,
  parameter int NUM_MAX  = 5,
  parameter int NUM_INIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_down,
  input  logic        key_space,
  output logic [1:0]  page,
  output logic [2:0]  total_number,
  output logic [39:0] status,
  output logic [3:0]  cur_select,
  output logic [3:0]  selected,
  output logic        selecting,
  output logic        cur_player,
  output logic [3:0]  predict,
  output logic [1:0]  game_end
);

  typedef enum logic [1:0] {
    PAGE_MAIN   = 2'd0,
    PAGE_HELP   = 2'd1,
    PAGE_CONFIG = 2'd2,
    PAGE_GAME   = 2'd3
  } page_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_UP,
    EV_LEFT,
    EV_RIGHT,
    EV_DOWN,
    EV_SPACE
  } event_e;

  localparam logic [2:0]  TOTAL_MIN   = 3'(NUM_MIN);
  localparam logic [2:0]  TOTAL_MAX   = 3'(NUM_MAX);
  localparam logic [2:0]  TOTAL_INIT  = 3'(NUM_INIT);
  localparam logic [39:0] STATUS_INIT = 40'h1111111111;

  page_e       page_q, page_d;
  logic [2:0]  total_q, total_d;
  logic [39:0] status_q, status_d;
  logic [3:0]  cur_q, cur_d;
  logic [3:0]  sel_q, sel_d;
  logic        selecting_q, selecting_d;
  logic        player_q, player_d;
  logic [1:0]  end_q, end_d;
  logic [1:0]  zero_hist_q, zero_hist_d;
  logic [4:0]  prev_keys_q;

  logic [4:0]  keys;
  logic [4:0]  rise;
  event_e      ev;

  logic        cur_row;
  logic [2:0]  cur_col;
  logic [3:0]  cur_base;
  logic [2:0]  col_left;
  logic [2:0]  col_right;
  logic [3:0]  toggle_idx;

  logic        sel_row;
  logic [3:0]  own_idx;
  logic [3:0]  oth_idx;
  logic [3:0]  own_val;
  logic [3:0]  oth_val;
  logic [4:0]  move_sum;
  logic [3:0]  move_val;
  logic [39:0] moved_status;
  logic [1:0]  new_hist;
  logic        row_clear;
  logic [4:0]  pred_sum;

  // Reads one 4-bit hand value out of the packed status vector.
  function automatic logic [3:0] hand_at(input logic [39:0] st, input logic [3:0] idx);
    return st[{idx, 2'b00} +: 4];
  endfunction

  assign keys = {key_up, key_left, key_right, key_down, key_space};
  assign rise = keys & ~prev_keys_q;

  // Keep only the highest-priority rising edge; the others are dropped this cycle.
  always_comb begin
    ev = EV_NONE;
    if (rise[4])      ev = EV_UP;
    else if (rise[3]) ev = EV_LEFT;
    else if (rise[2]) ev = EV_RIGHT;
    else if (rise[1]) ev = EV_DOWN;
    else if (rise[0]) ev = EV_SPACE;
  end

  // Cursor geometry: the row/column split and the wrapped neighbours inside the active columns.
  always_comb begin
    cur_row    = (cur_q >= 4'd5);
    cur_col    = cur_row ? 3'(cur_q - 4'd5) : cur_q[2:0];
    cur_base   = cur_row ? 4'd5 : 4'd0;
    col_left   = (cur_col == 3'd0) ? (total_q - 3'd1) : (cur_col - 3'd1);
    col_right  = (cur_col == (total_q - 3'd1)) ? 3'd0 : (cur_col + 3'd1);
    toggle_idx = cur_row ? {1'b0, cur_col} : (4'd5 + {1'b0, cur_col});
  end

  // Evaluate a candidate second pick: which hand belongs to the mover, and what the board looks like afterwards.
  always_comb begin
    sel_row  = (sel_q >= 4'd5);
    own_idx  = (sel_row == player_q) ? sel_q : cur_q;
    oth_idx  = (sel_row == player_q) ? cur_q : sel_q;
    own_val  = hand_at(status_q, own_idx);
    oth_val  = hand_at(status_q, oth_idx);
    move_sum = {1'b0, own_val} + {1'b0, oth_val};
    move_val = (move_sum >= 5'd10) ? 4'(move_sum - 5'd10) : move_sum[3:0];
    moved_status = status_q;
    moved_status[{own_idx, 2'b00} +: 4] = move_val;
    new_hist = {zero_hist_q[0], (oth_val == 4'd0)};
    row_clear = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if ((3'(c) < total_q) &&
          (hand_at(moved_status, player_q ? 4'(5 + c) : 4'(c)) != 4'd0)) begin
        row_clear = 1'b0;
      end
    end
  end

  // Next-state logic: page navigation, configuration and game moves for the single event of this cycle.
  always_comb begin
    page_d      = page_q;
    total_d     = total_q;
    status_d    = status_q;
    cur_d       = cur_q;
    sel_d       = sel_q;
    selecting_d = selecting_q;
    player_d    = player_q;
    end_d       = end_q;
    zero_hist_d = zero_hist_q;
    case (page_q)
      PAGE_MAIN: begin
        if (ev == EV_UP)        page_d = PAGE_CONFIG;
        else if (ev == EV_DOWN) page_d = PAGE_HELP;
      end
      PAGE_HELP: begin
        if (ev == EV_DOWN) page_d = PAGE_MAIN;
      end
      PAGE_CONFIG: begin
        case (ev)
          EV_LEFT:  if (total_q > TOTAL_MIN) total_d = total_q - 3'd1;
          EV_RIGHT: if (total_q < TOTAL_MAX) total_d = total_q + 3'd1;
          EV_DOWN:  page_d = PAGE_MAIN;
          EV_UP: begin
            page_d      = PAGE_GAME;
            status_d    = STATUS_INIT;
            cur_d       = 4'd0;
            sel_d       = 4'd0;
            selecting_d = 1'b0;
            player_d    = 1'b0;
            end_d       = 2'd0;
            zero_hist_d = 2'd0;
          end
          default: ;
        endcase
      end
      PAGE_GAME: begin
        case (ev)
          EV_LEFT:         cur_d = cur_base + {1'b0, col_left};
          EV_RIGHT:        cur_d = cur_base + {1'b0, col_right};
          EV_UP, EV_DOWN:  cur_d = toggle_idx;
          EV_SPACE: begin
            if (end_q != 2'd0) begin
              page_d = PAGE_MAIN;
            end else if (!selecting_q) begin
              sel_d       = cur_q;
              selecting_d = 1'b1;
            end else begin
              selecting_d = 1'b0;
              if ((sel_row != cur_row) && (own_val != 4'd0)) begin
                status_d    = moved_status;
                zero_hist_d = new_hist;
                player_d    = ~player_q;
                if (row_clear)              end_d = {player_q, ~player_q};
                else if (new_hist == 2'b11) end_d = 2'd3;
              end
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State registers; keys are remembered as already high at reset so a held key does not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q      <= PAGE_MAIN;
      total_q     <= TOTAL_INIT;
      status_q    <= STATUS_INIT;
      cur_q       <= 4'd0;
      sel_q       <= 4'd0;
      selecting_q <= 1'b0;
      player_q    <= 1'b0;
      end_q       <= 2'd0;
      zero_hist_q <= 2'd0;
      prev_keys_q <= 5'b11111;
    end else begin
      page_q      <= page_d;
      total_q     <= total_d;
      status_q    <= status_d;
      cur_q       <= cur_d;
      sel_q       <= sel_d;
      selecting_q <= selecting_d;
      player_q    <= player_d;
      end_q       <= end_d;
      zero_hist_q <= zero_hist_d;
      prev_keys_q <= keys;
    end
  end

  assign pred_sum     = {1'b0, hand_at(status_q, cur_q)} + {1'b0, hand_at(status_q, sel_q)};
  assign predict      = (pred_sum >= 5'd10) ? 4'(pred_sum - 5'd10) : pred_sum[3:0];
  assign page         = page_q;
  assign total_number = total_q;
  assign status       = status_q;
  assign cur_select   = cur_q;
  assign selected     = sel_q;
  assign selecting    = selecting_q;
  assign cur_player   = player_q;
  assign game_end     = end_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl with a small array-based game model.
module tb_game_ctrl;

  localparam logic [4:0] K_UP    = 5'b10000;
  localparam logic [4:0] K_LEFT  = 5'b01000;
  localparam logic [4:0] K_RIGHT = 5'b00100;
  localparam logic [4:0] K_DOWN  = 5'b00010;
  localparam logic [4:0] K_SPACE = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  drv;
  logic [1:0]  page;
  logic [2:0]  total_number;
  logic [39:0] status;
  logic [3:0]  cur_select;
  logic [3:0]  selected;
  logic        selecting;
  logic        cur_player;
  logic [3:0]  predict;
  logic [1:0]  game_end;

  game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_up       (drv[4]),
    .key_left     (drv[3]),
    .key_right    (drv[2]),
    .key_down     (drv[1]),
    .key_space    (drv[0]),
    .page         (page),
    .total_number (total_number),
    .status       (status),
    .cur_select   (cur_select),
    .selected     (selected),
    .selecting    (selecting),
    .cur_player   (cur_player),
    .predict      (predict),
    .game_end     (game_end)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pg;
    logic [2:0]  tot;
    logic [39:0] st;
    logic [3:0]  cur;
    logic [3:0]  sel;
    logic        sing;
    logic        plr;
    logic [3:0]  pred;
    logic [1:0]  gend;
  } snap_t;

  snap_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  int m_page, m_total, m_cur, m_sel, m_selecting, m_player, m_end;
  int m_zh[2];
  int m_hand[10];

  task automatic modelReset();
    m_page = 0; m_total = 2; m_cur = 0; m_sel = 0;
    m_selecting = 0; m_player = 0; m_end = 0;
    m_zh[0] = 0; m_zh[1] = 0;
    for (int i = 0; i < 10; i++) m_hand[i] = 1;
  endtask

  task automatic modelStep(input logic [4:0] k);
    int ev, row, col, own, oth, mover, allz;
    ev = -1;
    if (k[4])      ev = 0;
    else if (k[3]) ev = 1;
    else if (k[2]) ev = 2;
    else if (k[1]) ev = 3;
    else if (k[0]) ev = 4;
    case (m_page)
      0: begin
        if (ev == 0) m_page = 2;
        else if (ev == 3) m_page = 1;
      end
      1: if (ev == 3) m_page = 0;
      2: begin
        if (ev == 1 && m_total > 2) m_total--;
        else if (ev == 2 && m_total < 5) m_total++;
        else if (ev == 3) m_page = 0;
        else if (ev == 0) begin
          m_page = 3; m_cur = 0; m_sel = 0; m_selecting = 0;
          m_player = 0; m_end = 0; m_zh[0] = 0; m_zh[1] = 0;
          for (int i = 0; i < 10; i++) m_hand[i] = 1;
        end
      end
      default: begin
        row = m_cur / 5;
        col = m_cur % 5;
        if (ev == 1) m_cur = row * 5 + ((col == 0) ? m_total - 1 : col - 1);
        else if (ev == 2) m_cur = row * 5 + ((col == m_total - 1) ? 0 : col + 1);
        else if (ev == 0 || ev == 3) m_cur = (1 - row) * 5 + col;
        else if (ev == 4) begin
          if (m_end != 0) m_page = 0;
          else if (m_selecting == 0) begin
            m_sel = m_cur; m_selecting = 1;
          end else begin
            m_selecting = 0;
            if (m_sel / 5 != m_cur / 5) begin
              own = (m_sel / 5 == m_player) ? m_sel : m_cur;
              oth = (own == m_sel) ? m_cur : m_sel;
              if (m_hand[own] != 0) begin
                m_zh[1] = m_zh[0];
                m_zh[0] = (m_hand[oth] == 0) ? 1 : 0;
                m_hand[own] = (m_hand[own] + m_hand[oth]) % 10;
                mover = m_player;
                m_player = 1 - m_player;
                allz = 1;
                for (int c = 0; c < m_total; c++)
                  if (m_hand[mover * 5 + c] != 0) allz = 0;
                if (allz == 1) m_end = mover + 1;
                else if (m_zh[0] == 1 && m_zh[1] == 1) m_end = 3;
              end
            end
          end
        end
      end
    endcase
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    s.pg   = 2'(m_page);
    s.tot  = 3'(m_total);
    s.st   = '0;
    for (int i = 0; i < 10; i++) s.st[4 * i +: 4] = 4'(m_hand[i]);
    s.cur  = 4'(m_cur);
    s.sel  = 4'(m_sel);
    s.sing = 1'(m_selecting);
    s.plr  = 1'(m_player);
    s.pred = 4'((m_hand[m_cur] + m_hand[m_sel]) % 10);
    s.gend = 2'(m_end);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one key press for a single cycle and queue what the model says should follow.
  task automatic applyStimulus(input logic [4:0] k);
    @(negedge clk);
    drv = k;
    modelStep(k);
    exp_q.push_back(snapshot());
    @(negedge clk);
    drv = 5'b00000;
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput(input string tag);
    snap_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".page"},   40'(page),         40'(e.pg));
      chk({tag, ".total"},  40'(total_number), 40'(e.tot));
      chk({tag, ".status"}, status,            e.st);
      chk({tag, ".cur"},    40'(cur_select),   40'(e.cur));
      chk({tag, ".sel"},    40'(selected),     40'(e.sel));
      chk({tag, ".sing"},   40'(selecting),    40'(e.sing));
      chk({tag, ".player"}, 40'(cur_player),   40'(e.plr));
      chk({tag, ".pred"},   40'(predict),      40'(e.pred));
      chk({tag, ".end"},    40'(game_end),     40'(e.gend));
    end
  endtask

  task automatic press(input logic [4:0] k, input string tag);
    applyStimulus(k);
    checkOutput(tag);
  endtask

  task automatic doReset(input logic [4:0] hold);
    @(negedge clk);
    rst = 1'b1;
    drv = hold;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    exp_q.push_back(snapshot());
    checkOutput("reset");
    repeat (3) @(negedge clk);
    exp_q.push_back(snapshot());
    checkOutput("held");
    drv = 5'b00000;
  endtask

  task automatic gotoIdx(input int t);
    for (int n = 0; n < 2 && (m_cur / 5 != t / 5); n++) press(K_UP, "nav_row");
    for (int n = 0; n < 5 && (m_cur % 5 != t % 5); n++) press(K_RIGHT, "nav_col");
  endtask

  task automatic doMove(input int a, input int b, input string tag);
    gotoIdx(a);
    press(K_SPACE, {tag, ".pick1"});
    gotoIdx(b);
    press(K_SPACE, tag);
  endtask

  task automatic playPrefix();
    doMove(1, 6, "p1"); doMove(6, 1, "p2"); doMove(1, 6, "p3");
    doMove(6, 1, "p4"); doMove(0, 6, "p5"); doMove(6, 1, "p6");
    doMove(1, 6, "p7"); doMove(6, 0, "p8"); doMove(1, 6, "p9");
    chk("prefix_status", status, 40'h1112111109);
    chk("prefix_player", 40'(cur_player), 40'd1);
  endtask

  // Directed scenario: navigation, configuration, moves, invalid picks, win, draw and wide-row cursor.
  initial begin
    rst = 1'b1;
    drv = 5'b00000;
    modelReset();

    doReset(K_UP);
    chk("held_page", 40'(page), 40'd0);
    press(K_UP, "up_main");
    chk("page_cfg", 40'(page), 40'd2);
    repeat (5) press(K_RIGHT, "cfg_right");
    chk("total_max", 40'(total_number), 40'd5);
    repeat (5) press(K_LEFT, "cfg_left");
    chk("total_min", 40'(total_number), 40'd2);
    press(K_RIGHT, "cfg_right1");
    press(K_LEFT | K_RIGHT, "cfg_prio");
    chk("prio_left", 40'(total_number), 40'd2);
    press(K_UP, "start1");
    chk("game_page", 40'(page), 40'd3);
    chk("game_status", status, 40'h1111111111);

    doMove(0, 6, "mv06");
    chk("mv06_h0", 40'(status[3:0]), 40'd2);
    chk("mv06_player", 40'(cur_player), 40'd1);
    chk("mv06_pred", 40'(predict), 40'd3);
    doMove(5, 0, "mv50");
    chk("mv50_h5", 40'(status[23:20]), 40'd3);

    press(K_RIGHT, "cur_r1");
    press(K_RIGHT, "cur_wrap");
    chk("cur_wrap", 40'(cur_select), 40'd0);
    press(K_RIGHT, "cur_r2");
    press(K_UP, "cur_up");
    chk("cur_up", 40'(cur_select), 40'd6);

    doMove(0, 1, "same_row");
    chk("same_row_status", status, 40'h1111311112);
    chk("same_row_sing", 40'(selecting), 40'd0);
    chk("same_row_player", 40'(cur_player), 40'd0);

    press(K_SPACE, "presel");
    chk("presel_sing", 40'(selecting), 40'd1);
    doReset(5'b00000);
    chk("midreset_status", status, 40'h1111111111);

    press(K_UP, "w_cfg");
    press(K_UP, "w_start");
    playPrefix();
    doMove(6, 1, "w_p1");
    doMove(1, 5, "own_zero");
    chk("own_zero_status", status, 40'h1112111109);
    chk("own_zero_player", 40'(cur_player), 40'd0);
    chk("own_zero_sing", 40'(selecting), 40'd0);
    doMove(0, 5, "win");
    chk("win_h0", 40'(status[3:0]), 40'd0);
    chk("win_end", 40'(game_end), 40'd1);
    press(K_SPACE, "win_exit");
    chk("win_exit_page", 40'(page), 40'd0);

    press(K_UP, "d_cfg");
    press(K_UP, "d_start");
    playPrefix();
    doMove(5, 0, "d_m1");
    doMove(0, 5, "d_m2");
    doMove(6, 1, "draw");
    chk("draw_end", 40'(game_end), 40'd3);
    press(K_SPACE, "draw_exit");

    press(K_UP, "n5_cfg");
    repeat (3) press(K_RIGHT, "n5_right");
    press(K_UP, "n5_start");
    press(K_LEFT, "n5_left");
    chk("n5_wrap_left", 40'(cur_select), 40'd4);
    press(K_RIGHT, "n5_right_wrap");
    chk("n5_wrap_right", 40'(cur_select), 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
